// File: rtl/tf_stage_sequencer.sv
// Stage/beat loop controller feeding the twiddle-factor address generator.
// Optional define TF_SEQ_STALL_CNT_EN adds a saturating stall_cycles output.
module tf_stage_sequencer #(
    parameter int unsigned NUM_STAGES    = 10,
    parameter int unsigned CYC_PER_STAGE = 64,
    parameter int unsigned STAGE_GAP     = 2,
    parameter int unsigned P_W           = 4,
    parameter int unsigned CNT_W         = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic             stall,
    output logic [2:0]       conf,
    output logic [P_W-1:0]   p,
    output logic [8:0]       k,
    output logic [8:0]       i,
    output logic [CNT_W-1:0] cnt_addr_gen,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic             err
`ifdef TF_SEQ_STALL_CNT_EN
    ,
    output logic [15:0]      stall_cycles
`endif
);

    localparam logic [2:0]       MODE_NTT  = 3'b001;
    localparam logic [2:0]       MODE_INTT = 3'b011;
    localparam logic [P_W-1:0]   P_LAST    = P_W'(NUM_STAGES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CYC_PER_STAGE - 1);
    localparam int unsigned      GAP_W     = (STAGE_GAP > 1) ? $clog2(STAGE_GAP + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_INIT  = GAP_W'(STAGE_GAP);

    typedef enum logic [1:0] {StIdle, StRun, StGap, StFin} state_e;

    state_e           state_q, state_d;
    logic [2:0]       conf_q, conf_d;
    logic [P_W-1:0]   p_q, p_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [8:0]       k_q, k_d;
    logic [8:0]       i_q, i_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [GAP_W-1:0] gap_q, gap_d;

    logic             mode_legal;
    logic             last_stage;
    logic [P_W-1:0]   p_step;

    assign mode_legal = (mode == MODE_NTT) || (mode == MODE_INTT);
    // INTT walks p downwards, so its final stage is p = 0.
    assign last_stage = (conf_q == MODE_INTT) ? (p_q == '0) : (p_q == P_LAST);
    assign p_step     = (conf_q == MODE_INTT) ? (p_q - P_W'(1)) : (p_q + P_W'(1));

    always_comb begin
        state_d = state_q;
        conf_d  = conf_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        gap_d   = gap_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (mode_legal) begin
                        conf_d  = mode;
                        p_d     = (mode == MODE_INTT) ? P_LAST : '0;
                        cnt_d   = '0;
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                        state_d = StRun;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StRun: begin
                if (!stall) begin
                    if (cnt_q != CNT_LAST) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else if (last_stage) begin
                        // Present done together with the cleared outputs in the FIN cycle.
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        p_d     = '0;
                        cnt_d   = '0;
                        state_d = StFin;
                    end else if (STAGE_GAP == 0) begin
                        p_d   = p_step;
                        cnt_d = '0;
                    end else begin
                        valid_d = 1'b0;
                        gap_d   = GAP_INIT;
                        state_d = StGap;
                    end
                end
            end
            StGap: begin
                if (gap_q <= GAP_W'(1)) begin
                    p_d     = p_step;
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    state_d = StRun;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        k_d = (conf_d == MODE_NTT)  ? 9'(cnt_d) : 9'd0;
        i_d = (conf_d == MODE_INTT) ? 9'(cnt_d) : 9'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            conf_q  <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            k_q     <= '0;
            i_q     <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            conf_q  <= conf_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            i_q     <= i_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            gap_q   <= gap_d;
        end
    end

    assign conf         = conf_q;
    assign p            = p_q;
    assign k            = k_q;
    assign i            = i_q;
    assign cnt_addr_gen = cnt_q;
    assign valid        = valid_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;

`ifdef TF_SEQ_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (state_q == StIdle && start && mode_legal) begin
            stall_cnt_q <= '0;
        end else if (state_q == StRun && valid_q && stall && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_tf_stage_sequencer.sv
// Scoreboard bench for tf_stage_sequencer: randomized transforms and stalls against a
// stage/beat list model, plus a second instance with STAGE_GAP = 0, CYC_PER_STAGE = 1.
module tb_tf_stage_sequencer;

    localparam int NS  = 10;
    localparam int CPS = 64;
    localparam int GAP = 2;
    localparam int NOMINAL = NS * CPS + (NS - 1) * GAP + 1;

    typedef struct packed {
        logic [2:0] conf;
        logic [3:0] p;
        logic [6:0] cnt;
        logic [8:0] k;
        logic [8:0] i;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [2:0] mode = 3'b000;
    logic stall = 1'b0;
    logic [2:0] d_conf;
    logic [3:0] d_p;
    logic [8:0] d_k, d_i;
    logic [6:0] d_cnt;
    logic d_valid, d_busy, d_done, d_err;

    logic e_start = 1'b0;
    logic [2:0] e_mode = 3'b000;
    logic e_stall = 1'b0;
    logic [2:0] e_conf;
    logic [3:0] e_p;
    logic [8:0] e_k, e_i;
    logic [6:0] e_cnt;
    logic e_valid, e_busy, e_done, e_err;

`ifdef TF_SEQ_STALL_CNT_EN
    logic [15:0] d_stall_cycles, e_stall_cycles;
`endif

    tf_stage_sequencer #(
        .NUM_STAGES(NS), .CYC_PER_STAGE(CPS), .STAGE_GAP(GAP), .P_W(4), .CNT_W(7)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .stall(stall),
        .conf(d_conf), .p(d_p), .k(d_k), .i(d_i), .cnt_addr_gen(d_cnt),
        .valid(d_valid), .busy(d_busy), .done(d_done), .err(d_err)
`ifdef TF_SEQ_STALL_CNT_EN
        , .stall_cycles(d_stall_cycles)
`endif
    );

    tf_stage_sequencer #(
        .NUM_STAGES(10), .CYC_PER_STAGE(1), .STAGE_GAP(0), .P_W(4), .CNT_W(7)
    ) dut_edge (
        .clk(clk), .rst(rst), .start(e_start), .mode(e_mode), .stall(e_stall),
        .conf(e_conf), .p(e_p), .k(e_k), .i(e_i), .cnt_addr_gen(e_cnt),
        .valid(e_valid), .busy(e_busy), .done(e_done), .err(e_err)
`ifdef TF_SEQ_STALL_CNT_EN
        , .stall_cycles(e_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass = 0;
    beat_t exp_q[$];
    bit exp_active = 1'b0;
    int exp_done_cyc = 0;
    int stall_seen = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int exp_err = 0;
    logic [2:0] last_conf = 3'b000;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    endtask

    function automatic logic [63:0] outs_all();
        return 64'({d_conf, d_p, d_k, d_i, d_cnt, d_valid, d_busy, d_done, d_err});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a transform is just its ordered list of (stage, beat) pairs.
    task automatic push_transform(input logic [2:0] m);
        for (int s = 0; s < NS; s++) begin
            int pv;
            pv = (m == 3'b011) ? (NS - 1 - s) : s;
            for (int c = 0; c < CPS; c++) begin
                beat_t b;
                b.conf = m;
                b.p    = 4'(pv);
                b.cnt  = 7'(c);
                b.k    = (m == 3'b001) ? 9'(c) : 9'd0;
                b.i    = (m == 3'b011) ? 9'(c) : 9'd0;
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic issue_start(input logic [2:0] m);
        tick();
        stall = 1'b0;
        start = 1'b1;
        mode  = m;
        if (m == 3'b001 || m == 3'b011) begin
            push_transform(m);
            exp_active   = 1'b1;
            exp_done_cyc = cyc + NOMINAL;
            stall_seen   = 0;
            last_conf    = m;
        end else begin
            exp_err++;
        end
        tick();
        start = 1'b0;
        mode  = 3'($urandom_range(0, 7));
    endtask

    // stall_kind: 0 none, 1 random with pct, 2 five-cycle hold at p = 3, cnt = 63.
    task automatic run_until_done(input int stall_kind, input int pct, input bit poke_start);
        int n, d0, hold_left;
        bit held;
        n = 0; d0 = done_cnt; hold_left = 0; held = 1'b0;
        while (done_cnt == d0 && n < 4000) begin
            if (stall_kind == 1) begin
                stall = ($urandom_range(0, 99) < pct);
            end else if (stall_kind == 2) begin
                if (hold_left > 0) begin
                    stall = 1'b1;
                    hold_left--;
                end else if (!held && d_valid && d_p == 4'd3 && d_cnt == 7'd63) begin
                    stall = 1'b1;
                    hold_left = 4;
                    held = 1'b1;
                end else begin
                    stall = 1'b0;
                end
            end
            start = poke_start && (n == 100);
            mode  = 3'b001;
            tick();
            n++;
        end
        stall = 1'b0;
        start = 1'b0;
        check("done_seen", 64'(done_cnt - d0), 64'd1);
        if (stall_kind == 2) check("directed_stall_len", 64'(stall_seen), 64'd5);
`ifdef TF_SEQ_STALL_CNT_EN
        check("stall_cycles", 64'(d_stall_cycles), 64'(stall_seen));
`endif
        @(negedge clk);
        check("idle_after_done", 64'({d_busy, d_valid, d_done, d_p, d_cnt, d_conf}),
              64'({1'b0, 1'b0, 1'b0, 4'd0, 7'd0, last_conf}));
    endtask

    // Monitor: compares every presented beat against the head of the model queue.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (d_valid) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL beat_unexpected: got p=%0d cnt=%0d, required no beat",
                                 d_p, d_cnt);
                    end else begin
                        check("beat", 64'({d_conf, d_p, d_cnt, d_k, d_i, d_busy}),
                              64'({exp_q[0], 1'b1}));
                        if (!stall) void'(exp_q.pop_front());
                    end
                    if (stall) stall_seen++;
                end
                if (d_done) begin
                    done_cnt++;
                    check("done_expected", 64'(exp_active), 64'd1);
                    if (exp_active) begin
                        check("done_cycle", 64'(cyc), 64'(exp_done_cyc + stall_seen));
                        check("beats_left", 64'(exp_q.size()), 64'd0);
                    end
                    exp_active = 1'b0;
                end
                if (d_err) err_cnt++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of run, required $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, r, s;
        logic [2:0] m;

        #2;
        check("reset_outputs", outs_all(), 64'd0);
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("idle_outputs", outs_all(), 64'd0);

        // NTT, no stalls.
        issue_start(3'b001);
        run_until_done(0, 0, 1'b0);

        // INTT with random stalls and an ignored start mid-run.
        issue_start(3'b011);
        run_until_done(1, 25, 1'b1);

        // Five-cycle hold at the last beat of stage 3.
        issue_start(3'b001);
        run_until_done(2, 0, 1'b0);

        // Illegal mode.
        issue_start(3'b010);
        @(negedge clk);
        check("err_pulse", 64'({d_err, d_busy, d_valid, d_conf}),
              64'({1'b1, 1'b0, 1'b0, last_conf}));
        tick();
        @(negedge clk);
        check("err_single", 64'({d_err, d_busy, d_valid}), 64'd0);

        // Reset mid-run.
        issue_start(3'b001);
        n = 0;
        while (!(d_valid && d_p == 4'd4 && d_cnt == 7'd20) && n < 2000) begin
            tick();
            n++;
        end
        check("reached_p4_c20", 64'({d_p, d_cnt}), 64'({4'd4, 7'd20}));
        #1;
        rst = 1'b1;
        exp_q.delete();
        exp_active = 1'b0;
        #1;
        check("async_reset", outs_all(), 64'd0);
        repeat (2) tick();
        rst = 1'b0;
        s = done_cnt;
        repeat (5) tick();
        check("no_done_after_abort", 64'(done_cnt), 64'(s));
        issue_start(3'b001);
        run_until_done(0, 0, 1'b0);

        // Randomized transforms, including illegal modes.
        for (int t = 0; t < 5; t++) begin
            r = $urandom_range(0, 3);
            m = (r == 0) ? 3'b001 : (r == 1) ? 3'b011 : 3'($urandom_range(0, 7));
            issue_start(m);
            if (m == 3'b001 || m == 3'b011) begin
                run_until_done(1, $urandom_range(0, 30), 1'($urandom_range(0, 1)));
            end else begin
                @(negedge clk);
                check("rand_err", 64'({d_err, d_busy, d_conf}), 64'({1'b1, 1'b0, last_conf}));
            end
        end
        repeat (2) tick();
        check("err_pulses", 64'(err_cnt), 64'(exp_err));
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        // Back-to-back single-beat stages, with a start poked while busy.
        tick();
        e_start = 1'b1;
        e_mode  = 3'b001;
        s = cyc;
        tick();
        e_start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            e_start = 1'b0;
            if (c <= 10) begin
                check("edge_beat", 64'({e_valid, e_busy, e_p, e_cnt, e_k, e_i, e_done}),
                      64'({1'b1, 1'b1, 4'(c - 1), 7'd0, 9'd0, 9'd0, 1'b0}));
            end else if (c == 11) begin
                check("edge_done", 64'({e_done, e_valid, e_busy, cyc - s}),
                      64'({1'b1, 1'b0, 1'b0, 32'd11}));
            end else begin
                check("edge_idle", 64'({e_done, e_valid, e_busy, e_p}), 64'd0);
            end
            if (c == 3) begin
                e_start = 1'b1;
                e_mode  = 3'b011;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tf_stage_sequencer.md
Name: tf_stage_sequencer

Overview:
Loop-control stage that sits directly upstream of the twiddle-factor address generator. It walks the NTT/INTT stage index p and the per-stage beat counter and drives the generator's conf, p, k, i and cnt_addr_gen inputs. Beats are qualified by valid and can be stalled by the downstream butterfly pipeline. A fixed drain gap is inserted between stages, and done pulses at the end of a transform.

Parameters:
NUM_STAGES, 10, number of p values walked per transform (p = 0..NUM_STAGES-1)
CYC_PER_STAGE, 64, beats per stage (cnt_addr_gen = 0..CYC_PER_STAGE-1); legal range 1..128
STAGE_GAP, 2, idle cycles inserted between consecutive stages for pipeline drain; 0 allowed
P_W, 4, width of p
CNT_W, 7, width of cnt_addr_gen

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle request; sampled only in IDLE
mode  in  3  transform select, sampled with start: 3'b001 = NTT, 3'b011 = INTT, any other value rejected
stall  in  1  downstream hold; while high, the current beat is held and counters freeze
conf  out  3  latched mode; drives the address generator
p  out  P_W  current stage index
k  out  9  NTT group index, {2'b0, cnt_addr_gen} in NTT, 0 in INTT
i  out  9  INTT group index, {2'b0, cnt_addr_gen} in INTT, 0 in NTT
cnt_addr_gen  out  CNT_W  beat counter within the stage
valid  out  1  current outputs form a beat
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse after the final beat is accepted
err  out  1  one-cycle pulse when start carries an illegal mode

Behaviour:
- Reset (asynchronous, active-high) forces the FSM to IDLE. All outputs reset to 0: conf, p, k, i, cnt_addr_gen, valid, busy, done, err. All outputs are registered.
- FSM states: IDLE, RUN, GAP, FIN.
- IDLE, start with a legal mode:
  - conf <= mode.
  - p <= 0 for NTT, or NUM_STAGES-1 for INTT.
  - cnt_addr_gen <= 0; valid <= 1; busy <= 1.
  - Next state RUN. The first beat is visible the cycle after start.
- IDLE, start with an illegal mode: err <= 1 for one cycle, state stays IDLE, conf is unchanged.
- A beat is accepted on any RUN cycle with valid = 1 and stall = 0.
- RUN, stall = 1: every output holds its value.
- RUN, beat accepted, cnt_addr_gen < CYC_PER_STAGE-1: cnt_addr_gen increments by 1.
- RUN, beat accepted, cnt_addr_gen = CYC_PER_STAGE-1, not the last stage:
  - STAGE_GAP > 0: valid <= 0; go to GAP with the gap counter = STAGE_GAP.
  - STAGE_GAP = 0: step p, clear cnt_addr_gen, stay in RUN (back-to-back stages).
  - The last stage is p = NUM_STAGES-1 for NTT, p = 0 for INTT.
- Stepping p means p+1 for NTT and p-1 for INTT.
- GAP: the gap counter decrements each cycle regardless of stall. On its final cycle, step p, clear cnt_addr_gen, set valid <= 1 and return to RUN.
- RUN, last beat of the last stage accepted: valid <= 0; go to FIN.
- FIN: done <= 1 for one cycle; busy <= 0; p, k, i and cnt_addr_gen return to 0; next state IDLE. conf keeps the last mode.
- start is ignored outside IDLE, including in FIN.
- k and i are registered copies of cnt_addr_gen, zero-extended to 9 bits; the non-selected one is forced to 0. The downstream generator applies any per-p masking.
- Beat count per transform: NUM_STAGES*CYC_PER_STAGE.
- Total cycles from start to done with no stalls: NUM_STAGES*CYC_PER_STAGE + (NUM_STAGES-1)*STAGE_GAP + 1.
- Reset asserted mid-transform aborts immediately to the reset values. No done is issued.

Optional Feature:
TF_SEQ_STALL_CNT_EN:
- Defined: adds output stall_cycles[15:0]. It clears on an accepted start and increments on each RUN cycle with valid = 1 and stall = 1, saturating at 16'hFFFF. It holds its value after done and resets to 0.
- Not defined: the port and its counter are absent. All other behaviour is identical.

Test Plan:
- NTT, no stalls, defaults: start with mode = 3'b001 at cycle 0 -> first valid at cycle 1 with p = 0, k = 0; cnt_addr_gen reaches 63; 2 gap cycles with valid = 0; then p = 1; 640 beats total; done at cycle 659.
- INTT: mode = 3'b011 -> p sequence 9, 8, ..., 0; i tracks cnt_addr_gen; k stays 0; done after 640 beats.
- Stall: hold stall = 1 for 5 cycles at cnt_addr_gen = 63, p = 3 -> outputs frozen, still exactly 64 beats in that stage, done 5 cycles later than the unstalled case.
- Illegal mode: start with mode = 3'b010 -> err pulses once; busy, valid and conf stay unchanged; no beats issued.
- Reset mid-run: assert rst at p = 4, cnt_addr_gen = 20 -> all outputs 0 asynchronously, no done; a new start then behaves as in the first scenario.
- Edge parameters: STAGE_GAP = 0, CYC_PER_STAGE = 1 -> valid stays high continuously, p steps every beat, done at cycle 11. Also check that start pulsed during busy is ignored.
